// File: rtl/mul_shift_add.sv
// Sequential shift-and-add unsigned multiplier: one 64-bit carry-select addition per clock,
// WIDTH iterations per operation, valid/ready handshake on both sides.

module csa_64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_c_in,
  output logic [63:0] o_sum,
  output logic        o_c_out
);
  localparam int unsigned BLK  = 8;
  localparam int unsigned NBLK = 64 / BLK;

  logic [NBLK:0] w_carry;
  assign w_carry[0] = i_c_in;

  // Each block precomputes both carry-in cases; the ripple only drives the selects.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] w_s0;
    logic [BLK:0] w_s1;
    assign w_s0 = {1'b0, i_a[g*BLK +: BLK]} + {1'b0, i_b[g*BLK +: BLK]};
    assign w_s1 = w_s0 + (BLK+1)'(1);
    assign o_sum[g*BLK +: BLK] = w_carry[g] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
    assign w_carry[g+1]        = w_carry[g] ? w_s1[BLK]     : w_s0[BLK];
  end

  assign o_c_out = w_carry[NBLK];
endmodule

module mul_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [63:0]        r_mcand;
  logic [63:0]        w_mcand_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   w_mplier_next;
  logic [63:0]        r_acc;
  logic [63:0]        w_acc_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic               w_load_product;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_product;
  logic [63:0]        w_sum;
  logic               w_c_out_unused;

  csa_64 u_csa (
    .i_a     (r_acc),
    .i_b     (r_mcand),
    .i_c_in  (1'b0),
    .o_sum   (w_sum),
    .o_c_out (w_c_out_unused)
  );

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mcand     <= w_mcand_next;
      r_mplier    <= w_mplier_next;
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      if (w_load_product) r_product <= w_acc_next[2*WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_mcand_next   = r_mcand;
    w_mplier_next  = r_mplier;
    w_acc_next     = r_acc;
    w_cnt_next     = r_cnt;
    w_load_product = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mcand_next  = 64'(a);
          w_mplier_next = b;
          w_acc_next    = '0;
          w_cnt_next    = '0;
          w_state_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        w_acc_next    = r_mplier[0] ? w_sum : r_acc;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + CW'(1);
        // Last multiplier bit: commit the accumulated sum including this iteration.
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_load_product = 1'b1;
          w_state_next   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
endmodule

// File: tb/tb_mul_shift_add.sv
// Randomized self-checking bench for mul_shift_add (WIDTH=32) against an arithmetic reference.

module tb_mul_shift_add;
  localparam int unsigned WIDTH = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2*WIDTH-1:0] product;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mul_shift_add #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for the result, optional stall, then handoff.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input int stall, input bit intrude);
    logic [63:0] exp_p;
    int k;
    int busy_bad;
    int stall_bad;
    exp_p = 64'(op_a) * 64'(op_b);
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check("idle_ready", 64'(in_ready), 64'd1);
    a = op_a; b = op_b; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    if (intrude) begin
      a = WIDTH'(3); b = WIDTH'(5);
    end else begin
      in_valid = 1'b0;
    end
    k = 0; busy_bad = 0;
    while (!out_valid && k < 100) begin
      if (in_ready) busy_bad++;
      @(posedge clk); k++; @(negedge clk);
    end
    in_valid = 1'b0;
    check("busy_ready", 64'(busy_bad), 64'd0);
    check("latency", 64'(k), 64'(WIDTH));
    check("product", product, exp_p);
    if (stall > 0) begin
      stall_bad = 0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); @(negedge clk);
        if (!out_valid || in_ready || product !== exp_p) stall_bad++;
      end
      check("stall_hold", 64'(stall_bad), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check("handoff_valid", 64'(out_valid), 64'd0);
    check("handoff_ready", 64'(in_ready), 64'd1);
    check("product_kept", product, exp_p);
    out_ready = 1'b0;
  endtask

  // Start an operation, pulse reset after n edges, and confirm outputs clear at once.
  task automatic abort_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input int n_edges);
    a = op_a; b = op_b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (n_edges) begin
      @(posedge clk); @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(WIDTH'(10), WIDTH'(20), 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(32'h0, 32'h1234_5678, 0, 1'b0);
    run_op(32'h8000_0000, 32'h1, 0, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0, 1, 1'b0);
    run_op(WIDTH'(123), WIDTH'(456), 10, 1'b0);
    run_op(WIDTH'(7), WIDTH'(9), 3, 1'b1);

    // Result left in product (non-zero) makes the abort clear observable.
    run_op(WIDTH'(11), WIDTH'(13), 0, 1'b0);
    abort_op(WIDTH'(100), WIDTH'(100), 16);
    run_op(WIDTH'(6), WIDTH'(7), 0, 1'b0);
    abort_op(WIDTH'(1000), WIDTH'(3), 40);
    run_op(WIDTH'(5), WIDTH'(5), 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = (n % 4 == 0) ? WIDTH'($urandom_range(0, 255)) : $urandom;
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
